// File: rtl/inst_rom_arbiter.sv
// -----------------------------------------------------------------------------
// inst_rom_arbiter
//   Shares a single-ported instruction ROM between the IF-stage fetch port and
//   the load port used for constant reads from the instruction region. The two
//   ports are served round-robin. Each grant drives the ROM for one cycle, and
//   the returned word is registered and held for the winner until it is
//   accepted. Misaligned byte addresses never reach the ROM; they return an
//   error response with a zero data word instead.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   if_req_i/if_addr_i    IF request; held with a stable address until if_gnt_o
//   if_gnt_o              IF request accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o/if_err_o  registered IF response, held until if_rready_i
//   if_rready_i           IF accepts its response
//   ls_*                  same set of signals for the load port
//   rom_ce_o/rom_addr_o   ROM enable and byte address (combinational, only on a grant)
//   rom_inst_i            ROM read word (combinational from rom_addr_o)
//   conflict_cnt_o        saturating count of cycles in which a request had to wait
// -----------------------------------------------------------------------------
module inst_rom_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              if_rready_i,
    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_err_o,
    input  logic              ls_rready_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_inst_i,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;
    typedef enum logic [0:0] {PORT_IF = 1'b0, PORT_LS = 1'b1} port_e;

    state_e            state_q, state_d;
    port_e             owner_q, owner_d;
    port_e             last_owner_q, last_owner_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              slot_free_s;
    logic              grant_s;
    port_e             winner_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic              aligned_s;
    logic              cnt_inc_s;
    logic              resp_if_s;
    logic              resp_ls_s;

    // Arbitration: a new access is accepted only when the response slot is
    // empty or is being drained this very cycle.
    always_comb begin
        slot_free_s = (state_q == ST_IDLE) ||
                      ((owner_q == PORT_IF) ? if_rready_i : ls_rready_i);
        grant_s  = 1'b0;
        winner_s = PORT_IF;
        if (slot_free_s) begin
            if (if_req_i && ls_req_i) begin
                grant_s  = 1'b1;
                winner_s = (last_owner_q == PORT_LS) ? PORT_IF : PORT_LS;
            end else if (if_req_i) begin
                grant_s  = 1'b1;
                winner_s = PORT_IF;
            end else if (ls_req_i) begin
                grant_s  = 1'b1;
                winner_s = PORT_LS;
            end else begin
                grant_s  = 1'b0;
                winner_s = PORT_IF;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = PORT_IF;
        end
        win_addr_s = (winner_s == PORT_IF) ? if_addr_i : ls_addr_i;
        aligned_s  = (win_addr_s[1:0] == 2'b00);
        // A waiting cycle: a lost conflict, or any request blocked by a held response.
        cnt_inc_s  = slot_free_s ? (if_req_i && ls_req_i) : (if_req_i || ls_req_i);
    end

    // Next-state computation for the response slot and the conflict counter.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        if (grant_s) begin
            state_d      = ST_RESP;
            owner_d      = winner_s;
            last_owner_d = winner_s;
            rdata_d      = aligned_s ? rom_inst_i : {DATA_W{1'b0}};
            err_d        = ~aligned_s;
        end else if (slot_free_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
        if (cnt_inc_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset drops any held response at once and makes IF
    // the winner of the first conflict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_IF;
            last_owner_q <= PORT_LS;
            rdata_q      <= {DATA_W{1'b0}};
            err_q        <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign resp_if_s = (state_q == ST_RESP) && (owner_q == PORT_IF);
    assign resp_ls_s = (state_q == ST_RESP) && (owner_q == PORT_LS);

    // Grant and ROM strobes are gated by reset so they fall as soon as rst_i rises.
    assign if_gnt_o    = ~rst_i & grant_s & (winner_s == PORT_IF);
    assign ls_gnt_o    = ~rst_i & grant_s & (winner_s == PORT_LS);
    assign rom_ce_o    = ~rst_i & grant_s & aligned_s;
    assign rom_addr_o  = rom_ce_o ? win_addr_s : {ADDR_W{1'b0}};

    assign if_rvalid_o = resp_if_s;
    assign if_rdata_o  = resp_if_s ? rdata_q : {DATA_W{1'b0}};
    assign if_err_o    = resp_if_s & err_q;
    assign ls_rvalid_o = resp_ls_s;
    assign ls_rdata_o  = resp_ls_s ? rdata_q : {DATA_W{1'b0}};
    assign ls_err_o    = resp_ls_s & err_q;

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
module tb_inst_rom_arbiter;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0;
    logic [31:0] if_addr = 32'h0, ls_addr = 32'h0;
    logic        if_rready = 1'b1, ls_rready = 1'b1;
    logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, rom_ce;
    logic [31:0] if_rdata, ls_rdata, rom_addr, rom_inst;
    logic [CNT_W-1:0] cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the response currently held, who served last, waiting-cycle count.
    bit          m_valid;
    int          m_owner;   // 0 = IF, 1 = LS
    int          m_last;
    logic [31:0] m_data;
    bit          m_err;
    int          m_cnt;

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .if_rready_i(if_rready),
        .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_gnt_o(ls_gnt),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
        .ls_rready_i(ls_rready),
        .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst),
        .conflict_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h2408_0005;
        return (a * 32'h0019_660D) ^ 32'h3C01_8000;
    endfunction

    always_comb rom_inst = rom_fn(rom_addr);

    function automatic bit m_slot_free();
        return !m_valid || (m_owner == 0 ? if_rready : ls_rready);
    endfunction

    // -1 none, 0 IF, 1 LS
    function automatic int m_winner();
        if (!m_slot_free()) return -1;
        if (if_req && ls_req) return (m_last == 1) ? 0 : 1;
        if (if_req) return 0;
        if (ls_req) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] m_win_addr();
        return (m_winner() == 1) ? ls_addr : if_addr;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_owner = 0; m_last = 1; m_data = 32'h0; m_err = 1'b0; m_cnt = 0;
    endtask

    // Apply the clock edge to the model and the DUT, then return just after it.
    task automatic advance();
        int w;
        bit sf;
        logic [31:0] a;
        sf = m_slot_free();
        w  = m_winner();
        a  = m_win_addr();
        if ((sf && if_req && ls_req) || (!sf && (if_req || ls_req)))
            if (m_cnt < CMAX) m_cnt++;
        if (w >= 0) begin
            m_valid = 1'b1; m_owner = w; m_last = w;
            m_err   = (a[1:0] != 2'b00);
            m_data  = m_err ? 32'h0 : rom_fn(a);
        end else if (sf) begin
            m_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if_req = 1'b0; ls_req = 1'b0; if_rready = 1'b1; ls_rready = 1'b1;
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic test_reset();
        rst = 1'b1; model_reset();
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h0; ls_addr = 32'h40;
        @(negedge clk);
        n_vec++; if ({if_gnt, ls_gnt, rom_ce, if_rvalid, ls_rvalid, if_err, ls_err} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 0000000", {if_gnt, ls_gnt, rom_ce, if_rvalid, ls_rvalid, if_err, ls_err}); end
        n_vec++; if (rom_addr !== 32'h0 || if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_data got %h %h %h want 0", rom_addr, if_rdata, ls_rdata); end
        n_vec++; if (cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        if_req = 1'b0; ls_req = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_if_single();
        idle(2);
        if_req = 1'b1; if_addr = 32'h0000_0010;
        @(negedge clk);
        n_vec++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || rom_ce !== 1'b1) begin
            n_err++; $display("FAIL if1_gnt got gnt=%b/%b ce=%b want 1/0/1", if_gnt, ls_gnt, rom_ce); end
        n_vec++; if (rom_addr !== 32'h10) begin n_err++; $display("FAIL if1_addr got %h want 00000010", rom_addr); end
        advance(); if_req = 1'b0;
        @(negedge clk);
        n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2408_0005 || if_err !== 1'b0) begin
            n_err++; $display("FAIL if1_resp got v=%b d=%h e=%b want 1 24080005 0", if_rvalid, if_rdata, if_err); end
        advance();
    endtask

    task automatic test_alternate();
        rst = 1'b1; model_reset(); #2; rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_addr = 32'h40;
        if_rready = 1'b1; ls_rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (if_gnt !== (k % 2 == 0) || ls_gnt !== (k % 2 == 1)) begin
                n_err++; $display("FAIL alt_gnt k=%0d got %b%b want %b%b", k, if_gnt, ls_gnt, k % 2 == 0, k % 2 == 1); end
            n_vec++; if (cnt !== k[CNT_W-1:0]) begin n_err++; $display("FAIL alt_cnt k=%0d got %0d want %0d", k, cnt, k); end
            if (k % 2 == 1) begin
                n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== rom_fn(32'h0)) begin
                    n_err++; $display("FAIL alt_if_resp got %b %h want 1 %h", if_rvalid, if_rdata, rom_fn(32'h0)); end
            end else if (k > 0) begin
                n_vec++; if (ls_rvalid !== 1'b1 || ls_rdata !== rom_fn(32'h40)) begin
                    n_err++; $display("FAIL alt_ls_resp got %b %h want 1 %h", ls_rvalid, ls_rdata, rom_fn(32'h40)); end
            end
            advance();
        end
        idle(2);
    endtask

    task automatic test_misaligned();
        ls_req = 1'b1; ls_addr = 32'h0000_0042;
        @(negedge clk);
        n_vec++; if (ls_gnt !== 1'b1 || rom_ce !== 1'b0 || rom_addr !== 32'h0) begin
            n_err++; $display("FAIL mis_gnt got gnt=%b ce=%b a=%h want 1 0 0", ls_gnt, rom_ce, rom_addr); end
        advance(); ls_req = 1'b0;
        @(negedge clk);
        n_vec++; if (ls_rvalid !== 1'b1 || ls_err !== 1'b1 || ls_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
            n_err++; $display("FAIL mis_resp got v=%b e=%b d=%h ifv=%b want 1 1 0 0", ls_rvalid, ls_err, ls_rdata, if_rvalid); end
        advance();
    endtask

    task automatic test_backpressure();
        idle(1);
        if_req = 1'b1; if_addr = 32'h20; if_rready = 1'b0;
        advance();
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h44;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) if_rready = 1'b1;
            @(negedge clk);
            n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== rom_fn(32'h20)) begin
                n_err++; $display("FAIL bp_hold k=%0d got %b %h want 1 %h", k, if_rvalid, if_rdata, rom_fn(32'h20)); end
            n_vec++; if (ls_gnt !== (k == 3)) begin n_err++; $display("FAIL bp_ls_gnt k=%0d got %b want %b", k, ls_gnt, k == 3); end
            n_vec++; if (cnt !== m_cnt[CNT_W-1:0]) begin n_err++; $display("FAIL bp_cnt got %0d want %0d", cnt, m_cnt); end
            advance();
        end
        ls_req = 1'b0;
        @(negedge clk);
        n_vec++; if (ls_rvalid !== 1'b1 || ls_rdata !== rom_fn(32'h44) || if_rvalid !== 1'b0) begin
            n_err++; $display("FAIL bp_ls_resp got %b %h ifv=%b want 1 %h 0", ls_rvalid, ls_rdata, if_rvalid, rom_fn(32'h44)); end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] e;
        idle(1);
        for (int c = 0; c < 4; c++) begin
            if_req = (c < 3); if_addr = 32'(4 * c);
            @(negedge clk);
            if (c < 3) begin
                n_vec++; if (if_gnt !== 1'b1 || rom_addr !== 32'(4 * c)) begin
                    n_err++; $display("FAIL b2b_gnt c=%0d got %b %h want 1 %h", c, if_gnt, rom_addr, 4 * c); end
            end
            if (c > 0) begin
                e = q.pop_front();
                n_vec++; if (if_rvalid !== 1'b1 || if_rdata !== e) begin
                    n_err++; $display("FAIL b2b_resp c=%0d got %b %h want 1 %h", c, if_rvalid, if_rdata, e); end
            end
            if (c < 3) q.push_back(rom_fn(32'(4 * c)));
            advance();
        end
        idle(1);
    endtask

    task automatic test_reset_mid_and_saturate();
        if_req = 1'b1; if_addr = 32'h8; if_rready = 1'b0;
        advance();
        if_rready = 1'b1;    // would otherwise accept and grant again this cycle
        #2; rst = 1'b1; #1;
        n_vec++; if (if_rvalid !== 1'b0 || if_gnt !== 1'b0 || rom_ce !== 1'b0 || cnt !== 4'd0) begin
            n_err++; $display("FAIL rst_mid got v=%b g=%b ce=%b c=%0d want 0 0 0 0", if_rvalid, if_gnt, rom_ce, cnt); end
        model_reset();
        @(posedge clk); #1; rst = 1'b0;
        ls_req = 1'b1; ls_addr = 32'h80; ls_rready = 1'b1;
        @(negedge clk);
        n_vec++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || if_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rst_first got %b%b v=%b want 10 0", if_gnt, ls_gnt, if_rvalid); end
        advance();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_vec++; if (cnt !== m_cnt[CNT_W-1:0]) begin n_err++; $display("FAIL sat_step got %0d want %0d", cnt, m_cnt); end
            advance();
        end
        @(negedge clk);
        n_vec++; if (cnt !== 4'd15) begin n_err++; $display("FAIL sat_max got %0d want 15", cnt); end
        idle(2);
    endtask

    task automatic test_random();
        int w;
        logic [31:0] ea;
        bit ece;
        for (int k = 0; k < 400; k++) begin
            if (!if_req && ($urandom_range(0, 2) != 0)) begin
                if_req = 1'b1; if_addr = $urandom & 32'h0000_0FFF;
                if ($urandom_range(0, 3) != 0) if_addr[1:0] = 2'b00;
            end
            if (!ls_req && ($urandom_range(0, 2) != 0)) begin
                ls_req = 1'b1; ls_addr = $urandom & 32'h0000_0FFF;
                if ($urandom_range(0, 3) != 0) ls_addr[1:0] = 2'b00;
            end
            if_rready = ($urandom_range(0, 3) != 0);
            ls_rready = ($urandom_range(0, 3) != 0);
            w   = m_winner();
            ea  = m_win_addr();
            ece = (w >= 0) && (ea[1:0] == 2'b00);
            @(negedge clk);
            n_vec++; if (if_gnt !== (w == 0) || ls_gnt !== (w == 1)) begin
                n_err++; $display("FAIL rnd_gnt k=%0d got %b%b want %b%b", k, if_gnt, ls_gnt, w == 0, w == 1); end
            n_vec++; if (rom_ce !== ece || rom_addr !== (ece ? ea : 32'h0)) begin
                n_err++; $display("FAIL rnd_rom k=%0d got %b %h want %b %h", k, rom_ce, rom_addr, ece, ece ? ea : 32'h0); end
            n_vec++; if (if_rvalid !== (m_valid && m_owner == 0) || ls_rvalid !== (m_valid && m_owner == 1)) begin
                n_err++; $display("FAIL rnd_valid k=%0d got %b%b want %b%b", k, if_rvalid, ls_rvalid, m_valid && m_owner == 0, m_valid && m_owner == 1); end
            if (m_valid) begin
                n_vec++;
                if ((m_owner == 0 && (if_rdata !== m_data || if_err !== m_err)) ||
                    (m_owner == 1 && (ls_rdata !== m_data || ls_err !== m_err))) begin
                    n_err++; $display("FAIL rnd_data k=%0d port=%0d got %h/%b %h/%b want %h/%b", k, m_owner, if_rdata, if_err, ls_rdata, ls_err, m_data, m_err); end
            end
            n_vec++; if (cnt !== m_cnt[CNT_W-1:0]) begin n_err++; $display("FAIL rnd_cnt k=%0d got %0d want %0d", k, cnt, m_cnt); end
            advance();
            if (w == 0) if_req = 1'b0;
            if (w == 1) ls_req = 1'b0;
        end
        idle(2);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_if_single();
        test_alternate();
        test_misaligned();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_and_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
